// File: rtl/demux_scan_pkg.sv
// demux_scan_pkg
//   Shared types and constants for the display demux scan sequencer.
//   scan_state_t : IDLE / DRIVE / BLANK (BLANK is only reachable when the
//                  design is built with SCAN_BLANK_EN defined)
//   NUM_OUT      : number of demux outputs scanned
//   SEL_W        : width of the demux select
//   sel_inc      : next select value, wrapping NUM_OUT-1 -> 0
package demux_scan_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      DRIVE = 2'd1,
      BLANK = 2'd2
   } scan_state_t;

   localparam int NUM_OUT = 4;
   localparam int SEL_W   = 2;

   // NUM_OUT is a power of two, so natural overflow gives the wrap.
   function automatic logic [SEL_W-1:0] sel_inc(input logic [SEL_W-1:0] s);
      return s + 1'b1;
   endfunction

endpackage

// File: rtl/scan_prescaler.sv
// scan_prescaler
//   Clearable up-counter that times one drive slot or one blanking gap.
//   The counter runs from 0 up to 'term', raises 'tick' for that one cycle
//   and restarts from 0 on the following edge.
// Ports:
//   clk   in  system clock
//   rst   in  asynchronous active-high reset (count -> 0)
//   clr   in  synchronous clear; holds the count at 0 and masks tick
//   term  in  terminal count (cycles per period minus one)
//   tick  out high during the cycle in which count == term
module scan_prescaler #(
   parameter int CNT_W = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             clr,
   input  logic [CNT_W-1:0] term,
   output logic             tick
);

   logic [CNT_W-1:0] cnt;

   assign tick = (cnt == term) && !clr;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt <= '0;
      end else if (clr || tick) begin
         cnt <= '0;
      end else begin
         cnt <= cnt + 1'b1;
      end
   end

endmodule

// File: rtl/demux_scan_ctrl.sv
// demux_scan_ctrl
//   Drives the select lines and data input of a 1:4 demux so that the four
//   display outputs are enabled one at a time in rotation 0,1,2,3,0,...
//   Each output gets DIV clock cycles. When built with SCAN_BLANK_EN
//   defined, every slot is followed by BLANK_CYC cycles with dm_in low so
//   the select lines only ever move while the demux is idle.
// Parameters:
//   DIV        cycles per drive slot (>= 1)
//   BLANK_CYC  cycles per blanking gap (>= 1, used with SCAN_BLANK_EN)
//   CNT_W      prescaler width, must hold max(DIV, BLANK_CYC) - 1
// Ports:
//   clk         in  system clock
//   rst         in  asynchronous active-high reset
//   en          in  scan enable; low returns to IDLE on the next edge
//   mask[3:0]   in  mask[i]=1 allows output i to be driven
//   s1, s0      out demux select (registered)
//   dm_in       out demux data input (registered)
//   frame_done  out one-cycle pulse as the select wraps from 3 back to 0
//
// All outputs are flops fed from the current state/select registers, so they
// trail the internal state by one cycle; en is folded into the output flops
// directly so that dropping en clears the outputs on the very next edge.
import demux_scan_pkg::*;

module demux_scan_ctrl #(
   parameter int DIV       = 50000,
   parameter int BLANK_CYC = 500,
   parameter int CNT_W     = 16
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       en,
   input  logic [3:0] mask,
   output logic       s1,
   output logic       s0,
   output logic       dm_in,
   output logic       frame_done
);

   localparam int MAX_CYC = (DIV > BLANK_CYC) ? DIV : BLANK_CYC;

   if (DIV < 1 || BLANK_CYC < 1 || (MAX_CYC - 1) >= (2 ** CNT_W)) begin : g_param_check
      $error("demux_scan_ctrl: DIV/BLANK_CYC must be >= 1 and fit in CNT_W bits");
   end

   localparam logic [CNT_W-1:0] DIV_TERM = CNT_W'(DIV - 1);

   scan_state_t       state, state_next;
   logic [SEL_W-1:0]  sel, sel_next;
   logic              wrap_q, wrap_next;
   logic              pre_clr;
   logic              pre_tick;
   logic [CNT_W-1:0]  pre_term;

`ifdef SCAN_BLANK_EN
   localparam logic [CNT_W-1:0] BLANK_TERM = CNT_W'(BLANK_CYC - 1);
   assign pre_term = (state == BLANK) ? BLANK_TERM : DIV_TERM;
`else
   assign pre_term = DIV_TERM;
`endif

   scan_prescaler #(
      .CNT_W (CNT_W)
   ) u_prescaler (
      .clk  (clk),
      .rst  (rst),
      .clr  (pre_clr),
      .term (pre_term),
      .tick (pre_tick)
   );

   // Next-state logic. The prescaler restarts by itself after a tick, so a
   // slot/gap change never needs an explicit clear; clr is only used while
   // the scan is stopped so the first slot after enable is full length.
   always_comb begin
      state_next = state;
      sel_next   = sel;
      wrap_next  = 1'b0;
      pre_clr    = 1'b0;

      if (!en) begin
         state_next = IDLE;
         sel_next   = '0;
         pre_clr    = 1'b1;
      end else begin
         case (state)
            IDLE: begin
               state_next = DRIVE;
               sel_next   = '0;
               pre_clr    = 1'b1;
            end
            DRIVE: begin
               if (pre_tick) begin
`ifdef SCAN_BLANK_EN
                  state_next = BLANK;
`else
                  sel_next   = sel_inc(sel);
                  wrap_next  = (sel == SEL_W'(NUM_OUT - 1));
`endif
               end
            end
`ifdef SCAN_BLANK_EN
            BLANK: begin
               if (pre_tick) begin
                  state_next = DRIVE;
                  sel_next   = sel_inc(sel);
                  wrap_next  = (sel == SEL_W'(NUM_OUT - 1));
               end
            end
`endif
            default: begin
               state_next = IDLE;
               sel_next   = '0;
               pre_clr    = 1'b1;
            end
         endcase
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state  <= IDLE;
         sel    <= '0;
         wrap_q <= 1'b0;
      end else begin
         state  <= state_next;
         sel    <= sel_next;
         wrap_q <= wrap_next;
      end
   end

   // Output stage. wrap_q marks the cycle after the internal select wrapped,
   // which is exactly when the registered select lines show 00 again.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         s1         <= 1'b0;
         s0         <= 1'b0;
         dm_in      <= 1'b0;
         frame_done <= 1'b0;
      end else begin
         s1         <= en & sel[1];
         s0         <= en & sel[0];
         dm_in      <= en && (state == DRIVE) && mask[sel];
         frame_done <= en & wrap_q;
      end
   end

endmodule

// File: tb/tb_demux_scan_ctrl.sv
// tb_demux_scan_ctrl
//   Self-checking bench for demux_scan_ctrl with DIV=4, BLANK_CYC=2.
//   Follows the SCAN_BLANK_EN setting of the build it is compiled with.
//   A frame-position model pushes the expected {s1,s0,dm_in,frame_done}
//   for every clock edge into exp_q; each scenario pops and compares.
module tb_demux_scan_ctrl;

  localparam int DIV = 4;
  localparam int BLK = 2;
`ifdef SCAN_BLANK_EN
  localparam int SLOT = DIV + BLK;
`else
  localparam int SLOT = DIV;
`endif
  localparam int FRAME = 4 * SLOT;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       en = 1'b0;
  logic [3:0] mask = 4'h0;
  logic       s1, s0, dm_in, frame_done;

  int total = 0;
  int bad = 0;
  int cyc = 0;
  logic [3:0] exp_q[$];
  logic [3:0] got, exp;
  bit m_run = 1'b0;
  int m_t = 0;

  // clock / reset
  always #5 clk = ~clk;

  demux_scan_ctrl #(
    .DIV       (DIV),
    .BLANK_CYC (BLK),
    .CNT_W     (16)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .en         (en),
    .mask       (mask),
    .s1         (s1),
    .s0         (s0),
    .dm_in      (dm_in),
    .frame_done (frame_done)
  );

  // Expected outputs at frame position t (t counts output cycles since the
  // first driven slot began).
  function automatic logic [3:0] model_out(input int t, input logic [3:0] m);
    int pos, slot, off;
    logic [1:0] sel_v;
    logic dm_v, fd_v;
    pos   = t % FRAME;
    slot  = pos / SLOT;
    off   = pos % SLOT;
    sel_v = 2'(slot);
    dm_v  = (off < DIV) && m[slot];
    fd_v  = (t > 0) && (pos == 0);
    return {sel_v, dm_v, fd_v};
  endfunction

  // driver: apply inputs for one edge and queue what that edge must produce
  task automatic drive_cycle(input logic en_v, input logic [3:0] mask_v);
    @(negedge clk);
    en   = en_v;
    mask = mask_v;
    if (!en_v) begin
      exp_q.push_back(4'b0000);
      m_run = 1'b0;
    end else if (!m_run) begin
      exp_q.push_back(4'b0000);
      m_run = 1'b1;
      m_t   = 0;
    end else begin
      exp_q.push_back(model_out(m_t, mask_v));
      m_t++;
    end
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic test_reset();
    #1;
    got = {s1, s0, dm_in, frame_done};
    total++;
    if (got !== 4'b0000) begin
      bad++;
      $display("FAIL reset_hold cyc=%0d got=%b exp=0000", cyc, got);
    end
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      drive_cycle(1'b0, 4'hf);
      got = {s1, s0, dm_in, frame_done};
      exp = exp_q.pop_front();
      total++;
      if (got !== exp) begin
        bad++;
        $display("FAIL reset_idle cyc=%0d got=%b exp=%b", cyc, got, exp);
      end
    end
    // run into the start of slot 2, then reset between clock edges
    for (int i = 0; i < 2 * SLOT + 2; i++) begin
      drive_cycle(1'b1, 4'hf);
      got = {s1, s0, dm_in, frame_done};
      exp = exp_q.pop_front();
      total++;
      if (got !== exp) begin
        bad++;
        $display("FAIL reset_run cyc=%0d got=%b exp=%b", cyc, got, exp);
      end
    end
    total++;
    if ({s1, s0, dm_in} !== 3'b101) begin
      bad++;
      $display("FAIL reset_pre_sel cyc=%0d got=%b exp=101", cyc, {s1, s0, dm_in});
    end
    #2;
    rst = 1'b1;
    #1;
    got = {s1, s0, dm_in, frame_done};
    total++;
    if (got !== 4'b0000) begin
      bad++;
      $display("FAIL reset_async cyc=%0d got=%b exp=0000", cyc, got);
    end
    exp_q.delete();
    m_run = 1'b0;
    en = 1'b0;
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_rotation();
    int pulses, high_cnt, first_fd, second_fd;
    pulses = 0; high_cnt = 0; first_fd = -1; second_fd = -1;
    drive_cycle(1'b0, 4'hf);
    exp = exp_q.pop_front();
    got = {s1, s0, dm_in, frame_done};
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL rot_idle cyc=%0d got=%b exp=%b", cyc, got, exp);
    end
    for (int i = 0; i < 2 * FRAME + 2; i++) begin
      drive_cycle(1'b1, 4'hf);
      got = {s1, s0, dm_in, frame_done};
      exp = exp_q.pop_front();
      total++;
      if (got !== exp) begin
        bad++;
        $display("FAIL rot cyc=%0d got=%b exp=%b", cyc, got, exp);
      end
      if (dm_in === 1'b1) high_cnt++;
      if (frame_done === 1'b1) begin
        pulses++;
        if (first_fd < 0) first_fd = cyc;
        else if (second_fd < 0) second_fd = cyc;
      end
    end
    total++;
    if (pulses !== 2) begin
      bad++;
      $display("FAIL rot_pulses got=%0d exp=2", pulses);
    end
    total++;
    if (second_fd - first_fd !== FRAME) begin
      bad++;
      $display("FAIL rot_period got=%0d exp=%0d", second_fd - first_fd, FRAME);
    end
    // 2 full frames of driving plus the first cycle of the third frame
    total++;
    if (high_cnt !== 8 * DIV + 1) begin
      bad++;
      $display("FAIL rot_high got=%0d exp=%0d", high_cnt, 8 * DIV + 1);
    end
  endtask

  task automatic test_mask();
    logic [3:0] m;
    drive_cycle(1'b0, 4'b0101);
    exp = exp_q.pop_front();
    got = {s1, s0, dm_in, frame_done};
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL mask_idle cyc=%0d got=%b exp=%b", cyc, got, exp);
    end
    for (int i = 0; i < FRAME + 1; i++) begin
      drive_cycle(1'b1, 4'b0101);
      got = {s1, s0, dm_in, frame_done};
      exp = exp_q.pop_front();
      total++;
      if (got !== exp) begin
        bad++;
        $display("FAIL mask_0101 cyc=%0d got=%b exp=%b", cyc, got, exp);
      end
    end
    // restart, then switch to 1000 two cycles into slot 0
    drive_cycle(1'b0, 4'b0101);
    void'(exp_q.pop_front());
    for (int i = 0; i < FRAME + 2; i++) begin
      m = (i < 3) ? 4'b0101 : 4'b1000;
      drive_cycle(1'b1, m);
      got = {s1, s0, dm_in, frame_done};
      exp = exp_q.pop_front();
      total++;
      if (got !== exp) begin
        bad++;
        $display("FAIL mask_change cyc=%0d got=%b exp=%b", cyc, got, exp);
      end
      if (i == 3) begin
        total++;
        if (dm_in !== 1'b0) begin
          bad++;
          $display("FAIL mask_fall cyc=%0d got=%b exp=0", cyc, dm_in);
        end
      end
    end
  endtask

  task automatic test_enable();
    logic e;
    drive_cycle(1'b0, 4'hf);
    void'(exp_q.pop_front());
    for (int i = 0; i < 2 * SLOT + 3 + 3 + 3; i++) begin
      e = !(i >= 2 * SLOT + 3 && i < 2 * SLOT + 6);
      drive_cycle(e, 4'hf);
      got = {s1, s0, dm_in, frame_done};
      exp = exp_q.pop_front();
      total++;
      if (got !== exp) begin
        bad++;
        $display("FAIL enable cyc=%0d got=%b exp=%b", cyc, got, exp);
      end
    end
  endtask

  task automatic test_all_masked();
    int pulses, high_cnt;
    pulses = 0; high_cnt = 0;
    drive_cycle(1'b0, 4'h0);
    void'(exp_q.pop_front());
    for (int i = 0; i < 2 * FRAME + 2; i++) begin
      drive_cycle(1'b1, 4'h0);
      got = {s1, s0, dm_in, frame_done};
      exp = exp_q.pop_front();
      total++;
      if (got !== exp) begin
        bad++;
        $display("FAIL masked cyc=%0d got=%b exp=%b", cyc, got, exp);
      end
      if (dm_in === 1'b1) high_cnt++;
      if (frame_done === 1'b1) pulses++;
    end
    total++;
    if (pulses !== 2 || high_cnt !== 0) begin
      bad++;
      $display("FAIL masked_summary pulses=%0d high=%0d exp pulses=2 high=0", pulses, high_cnt);
    end
  endtask

  task automatic test_back_to_back();
    logic e;
    logic [3:0] m;
    m = 4'hf;
    for (int i = 0; i < 200; i++) begin
      e = ($urandom_range(0, 29) != 0);
      if ($urandom_range(0, 3) == 0) m = 4'($urandom_range(0, 15));
      drive_cycle(e, m);
      got = {s1, s0, dm_in, frame_done};
      exp = exp_q.pop_front();
      total++;
      if (got !== exp) begin
        bad++;
        $display("FAIL random cyc=%0d got=%b exp=%b", cyc, got, exp);
      end
    end
  endtask

  initial begin
    test_reset();
    test_rotation();
    test_mask();
    test_enable();
    test_all_masked();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/demux_scan_ctrl.md
# demux_scan_ctrl

Sequencer for the 1:4 demultiplexer in the visitor-counter display path. It generates the demux select lines (`s1`, `s0`) and the demux data input (`dm_in`) so that the four demux outputs are enabled one at a time in a fixed rotation at a programmable rate. An optional blanking gap separates digit slots to suppress ghosting. A per-output mask lets the counter logic suppress individual outputs, for example for leading-zero blanking.

## Interface
- `DIV`, default 50000: clock cycles per drive slot (≥1).
- `BLANK_CYC`, default 500: clock cycles per blanking gap (≥1; used only with `SCAN_BLANK_EN`).
- `CNT_W`, default 16: prescaler width; must hold max(`DIV`, `BLANK_CYC`) − 1.

Ports:
- `clk`  in  1  system clock; all state updates on rising edge.
- `rst`  in  1  reset, asynchronous, active-high.
- `en`  in  1  scan enable; low forces IDLE.
- `mask`  in  4  per-output enable; `mask[i]`=1 lets output i be driven.
- `s1`  out  1  demux select MSB (registered).
- `s0`  out  1  demux select LSB (registered).
- `dm_in`  out  1  demux data input (registered).
- `frame_done`  out  1  one-cycle pulse when a full 4-output rotation completes.

## Operation
- States: IDLE, DRIVE, BLANK (BLANK exists only with `SCAN_BLANK_EN`).
- Reset values: state=IDLE; `{s1,s0}`=00; `dm_in`=0; `frame_done`=0; prescaler=0.
- IDLE: `dm_in`=0 and sel=00. If `en`=1, the next state is DRIVE with sel=00 and prescaler=0.
- DRIVE: `dm_in`=`mask[sel]`. The prescaler increments every cycle. The terminal tick is prescaler==`DIV`−1.
  - On the tick with `SCAN_BLANK_EN`: go to BLANK, clear the prescaler, hold sel.
  - On the tick without `SCAN_BLANK_EN`: sel←sel+1 mod 4, clear the prescaler, stay in DRIVE.
- BLANK: `dm_in`=0 and sel held. On prescaler==`BLANK_CYC`−1: sel←sel+1 mod 4, clear the prescaler, go to DRIVE.
- Wrap-around: sel 11→00 is legal and continuous. `frame_done` pulses for exactly one cycle in the cycle where sel is updated from 11 to 00.
- `en` deassert in any state: on the next edge the state becomes IDLE, sel=00, `dm_in`=0, and the prescaler is cleared. No `frame_done` is generated. Re-enable restarts at output 0.
- `mask` is sampled every cycle. A mid-slot change takes effect on `dm_in` at the next edge; the slot timing is unaffected.
- `mask`=0000: the rotation continues with `dm_in`=0 and `frame_done` keeps pulsing.
- `rst` mid-operation: all outputs go to their reset values immediately (asynchronously).

## Timing
- Output latency: one cycle from the state decision; all outputs are flop outputs with no combinational paths from inputs.
- `en` 0→1 sampled at edge k: at edge k+1, `dm_in`=`mask[0]` and sel=00.
- Slot length: `DIV` cycles of DRIVE, plus `BLANK_CYC` cycles of BLANK when that feature is compiled in.
- Frame period:
  - 4×(`DIV`+`BLANK_CYC`) cycles with `SCAN_BLANK_EN`.
  - 4×`DIV` cycles without it.
- The select lines never change while `dm_in`=1 when `SCAN_BLANK_EN` is defined.

## Configuration
- Macro: `SCAN_BLANK_EN`.
- Defined: the BLANK state and `BLANK_CYC` are active; `dm_in` is forced to 0 for `BLANK_CYC` cycles before every select change.
- Undefined: there is no BLANK state; select advances directly DRIVE→DRIVE, and `BLANK_CYC` is ignored.

## Structure
- Package `demux_scan_pkg`:
  - state enum `scan_state_t` {IDLE, DRIVE, BLANK}
  - constant `NUM_OUT`=4
  - constant `SEL_W`=2
- Sub-module `scan_prescaler`:
  - loadable/clearable up-counter of `CNT_W` bits
  - inputs: terminal value and clear
  - output: one-cycle terminal tick
- The top level holds the FSM, the sel register and the output flops.

## Test plan
Unless noted, `DIV`=4 and `BLANK_CYC`=2.
- Reset: assert `rst` asynchronously mid-DRIVE on sel=10 → immediately `s1`=`s0`=0, `dm_in`=0, `frame_done`=0.
- Basic rotation with `SCAN_BLANK_EN`, `mask`=1111, `en`=1 →
  - sel sequence 00,01,10,11 repeats;
  - each slot is 4 cycles of `dm_in`=1 followed by 2 cycles of `dm_in`=0;
  - frame period is 24 cycles;
  - `frame_done` is high for 1 cycle per frame.
- Without `SCAN_BLANK_EN`, `mask`=1111 → `dm_in` is constantly 1, sel advances every 4 cycles, frame period is 16 cycles.
- Mask: `mask`=0101 → `dm_in`=1 only in slots 00 and 10. Change to 1000 mid-slot 00 → `dm_in` falls at the next edge and the slot length is unchanged.
- Enable: drop `en` during slot 10 → IDLE next edge with sel=00, `dm_in`=0, no `frame_done`. Raise `en` → DRIVE with sel=00 one cycle later.
- All-masked: `mask`=0000 for 2 frames → `dm_in` stays 0 and `frame_done` still pulses every 24 cycles.
